dm_responder: RTL

Data-memory responder for the pipelined MIPS core: the memory-side end of the core's load/store request interface. Accepts one word-aligned request at a time, waits a fixed number of cycles, then commits a byte-enabled store or returns a read word with a one-cycle response pulse. Sits between the MEM stage and the on-chip data RAM. The core stalls until the response arrives.

---
 rtl/dm_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word-aligned load/store, waits a fixed
// number of cycles, then commits the store or returns the read word.
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    // state  | meaning
    // IDLE   | ready for a request
    // WAIT   | counting wait states for the latched request
    // RESP   | one-cycle response pulse, no accept
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        first_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  commit_we;
    logic [29:0]           commit_addr;
    logic [3:0]            commit_be;
    logic [31:0]           commit_wdata;
    logic [ADDR_WIDTH-1:0] commit_idx;
    logic                  commit_oor;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // With zero wait states the commit happens at the accept edge, so the
    // request is taken straight from the inputs instead of the latches.
    always_comb begin
        accept = req_valid && (state_q == S_IDLE);
        if (state_q == S_IDLE) begin
            commit_we    = req_we;
            commit_addr  = req_addr[31:2];
            commit_be    = req_be;
            commit_wdata = req_wdata;
        end else begin
            commit_we    = we_q;
            commit_addr  = addr_q;
            commit_be    = be_q;
            commit_wdata = wdata_q;
        end
        commit_idx = commit_addr[ADDR_WIDTH-1:0];
        commit_oor = |commit_addr[29:ADDR_WIDTH];
        enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && !first_q && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[31:2];
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            first_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Counter is loaded in the first WAIT cycle, then runs down to 0.
                    if (first_q) begin
                        cnt_q   <= CNT_INIT;
                        first_q <= 1'b0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (enter_resp) begin
                valid_q <= 1'b1;
                err_q   <= commit_oor;
                rdata_q <= (!commit_we && !commit_oor) ? mem_q[commit_idx] : 32'd0;
                if (commit_we && !commit_oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (commit_be[b]) begin
                            mem_q[commit_idx][8*b +: 8] <= commit_wdata[8*b +: 8];
                        end
                    end
                end
            end else if (state_q == S_RESP) begin
                valid_q <= 1'b0;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
